// File: rtl/pift_mon_pkg.sv
// Shared types for the PIFT taint monitor: FSM state encoding and the
// default-width change record.
package pift_mon_pkg;

  localparam int unsigned REC_SRC_W = 3;
  localparam int unsigned REC_SUM_W = 8;
  localparam int unsigned REC_CYC_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN
  } state_t;

  typedef struct packed {
    logic [REC_SRC_W-1:0] src;
    logic [REC_SUM_W-1:0] value;
    logic [REC_CYC_W-1:0] cycle;
  } rec_t;

  // Index width for n sources, never below one bit.
  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pift_rec_fifo.sv
// Synchronous record FIFO with full/empty flags; no fall-through, so a word
// written at an edge is first visible after that edge.
module pift_rec_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a push when a pop frees a slot at the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/pift_taint_monitor.sv
// Watches NUM_SRC taint_sum sources, queues one change record per cycle
// (lowest pending source first) and tracks coalescing and first taint.
module pift_taint_monitor
  import pift_mon_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned SUM_WIDTH   = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned CYCLE_WIDTH = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_SRC*SUM_WIDTH-1:0]     taint_sum,
  output logic                             rec_valid,
  input  logic                             rec_ready,
  output logic [src_width(NUM_SRC)-1:0]    rec_src,
  output logic [SUM_WIDTH-1:0]             rec_value,
  output logic [CYCLE_WIDTH-1:0]           rec_cycle,
  output logic [15:0]                      coalesce_count,
  output logic                             first_taint,
  output logic [CYCLE_WIDTH-1:0]           first_taint_cycle
);

  localparam int unsigned SRC_W = src_width(NUM_SRC);

  typedef struct packed {
    logic [SRC_W-1:0]       src;
    logic [SUM_WIDTH-1:0]   value;
    logic [CYCLE_WIDTH-1:0] cycle;
  } mon_rec_t;

  state_t                             r_state;
  logic [NUM_SRC-1:0][SUM_WIDTH-1:0]  r_prev;
  logic [NUM_SRC-1:0]                 r_pend;
  logic [CYCLE_WIDTH-1:0]             r_cnt;
  logic [15:0]                        r_coal;
  logic                               r_ft;
  logic [CYCLE_WIDTH-1:0]             r_ftc;

  logic [NUM_SRC-1:0] w_chg;
  logic [NUM_SRC-1:0] w_pushmask;
  logic               w_hit;
  logic [SRC_W-1:0]   w_idx;
  logic               w_push;
  logic               w_full;
  logic               w_empty;
  logic [16:0]        w_coal_sum;
  mon_rec_t           w_rec;
  mon_rec_t           w_head;

  always_comb begin
    w_chg = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      w_chg[i] = (taint_sum[i*SUM_WIDTH +: SUM_WIDTH] != r_prev[i]);
  end

  // Descending scan so the lowest pending index is the one left standing.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (r_pend[i-1]) begin
        w_hit = 1'b1;
        w_idx = SRC_W'(i - 1);
      end
    end
  end

  always_comb begin
    w_push     = (r_state == RUN) && enable && w_hit && (!w_full || (rec_valid && rec_ready));
    w_pushmask = w_push ? (NUM_SRC'(1) << w_idx) : '0;
    // A change on the source being pushed this edge is not an overwrite.
    w_coal_sum = {1'b0, r_coal} + 17'($countones(r_pend & ~w_pushmask & w_chg));
    w_rec.src   = w_idx;
    w_rec.value = r_prev[w_idx];
    w_rec.cycle = r_cnt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_prev  <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_coal  <= '0;
      r_ft    <= 1'b0;
      r_ftc   <= '0;
    end else begin
      case (r_state)
        IDLE: if (enable) r_state <= ARM;
        ARM: begin
          r_pend <= '0;
          if (!enable) begin
            r_state <= IDLE;
          end else begin
            r_prev  <= taint_sum;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            r_state <= IDLE;
            r_pend  <= '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_pend <= (r_pend & ~w_pushmask) | w_chg;
            r_prev <= taint_sum;
            r_coal <= w_coal_sum[16] ? '1 : w_coal_sum[15:0];
            if (!r_ft && (|taint_sum)) begin
              r_ft  <= 1'b1;
              r_ftc <= r_cnt;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  pift_rec_fifo #(
    .WIDTH($bits(mon_rec_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (w_rec),
    .i_pop   (rec_ready),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rec_valid         = !w_empty;
  assign rec_src           = w_head.src;
  assign rec_value         = w_head.value;
  assign rec_cycle         = w_head.cycle;
  assign coalesce_count    = r_coal;
  assign first_taint       = r_ft;
  assign first_taint_cycle = r_ftc;

endmodule

// File: tb/tb_pift_taint_monitor.sv
// Scoreboard bench for pift_taint_monitor: a behavioural model predicts
// records and flags; a negedge monitor checks whatever the DUT presents.
module tb_pift_taint_monitor;

  localparam int NS = 8;
  localparam int SW = 4;
  localparam int FD = 4;
  localparam int CW = 32;

  logic              clock = 1'b0;
  logic              reset;
  logic              enable;
  logic [NS*SW-1:0]  taint_sum;
  logic              rec_valid;
  logic              rec_ready;
  logic [2:0]        rec_src;
  logic [SW-1:0]     rec_value;
  logic [CW-1:0]     rec_cycle;
  logic [15:0]       coalesce_count;
  logic              first_taint;
  logic [CW-1:0]     first_taint_cycle;

  pift_taint_monitor #(
    .NUM_SRC(NS), .SUM_WIDTH(SW), .FIFO_DEPTH(FD), .CYCLE_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .taint_sum(taint_sum),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_src(rec_src),
    .rec_value(rec_value), .rec_cycle(rec_cycle), .coalesce_count(coalesce_count),
    .first_taint(first_taint), .first_taint_cycle(first_taint_cycle)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          src;
    int          value;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb[$];
  exp_t got[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: what the spec says should be happening.
  bit          m_arm, m_run;
  int          m_prev[NS];
  bit          m_pend[NS];
  logic [31:0] m_cnt;
  int          m_coal;
  bit          m_ft;
  logic [31:0] m_ftc;
  int          m_occ;
  bit          mp_pop, mp_push;
  int          mp_j;

  function automatic int ts(input int i);
    return int'(taint_sum[i*SW +: SW]);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_arm = 0; m_run = 0; m_cnt = '0; m_coal = 0; m_ft = 0; m_ftc = '0; m_occ = 0;
      for (int i = 0; i < NS; i++) begin m_prev[i] = 0; m_pend[i] = 0; end
      sb.delete();
    end else begin
      mp_pop  = (m_occ > 0) && rec_ready;
      mp_push = 0;
      if (!enable) begin
        m_arm = 0; m_run = 0;
        for (int i = 0; i < NS; i++) m_pend[i] = 0;
      end else if (m_run) begin
        mp_j = -1;
        for (int i = NS - 1; i >= 0; i--) if (m_pend[i]) mp_j = i;
        if (mp_j >= 0 && (m_occ < FD || mp_pop)) begin
          sb.push_back('{mp_j, m_prev[mp_j], m_cnt});
          m_pend[mp_j] = 0;
          mp_push = 1;
        end
        for (int i = 0; i < NS; i++) begin
          if (ts(i) != m_prev[i]) begin
            if (m_pend[i] && m_coal < 65535) m_coal++;
            m_pend[i] = 1;
            m_prev[i] = ts(i);
          end
        end
        if (!m_ft && taint_sum != '0) begin m_ft = 1; m_ftc = m_cnt; end
        m_cnt = m_cnt + 1;
      end else if (m_arm) begin
        for (int i = 0; i < NS; i++) begin m_prev[i] = ts(i); m_pend[i] = 0; end
        m_cnt = '0; m_arm = 0; m_run = 1;
      end else begin
        m_arm = 1;
      end
      m_occ = m_occ + int'(mp_push) - int'(mp_pop);
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      check("rec_valid", rec_valid, m_occ > 0);
      check("coalesce_count", coalesce_count, m_coal);
      check("first_taint", first_taint, m_ft);
      check("first_taint_cycle", first_taint_cycle, m_ftc);
      if (rec_valid) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_record actual src=%0d value=%0d cycle=%0d required none",
                   rec_src, rec_value, rec_cycle);
        end else begin
          check("rec_src", rec_src, sb[0].src);
          check("rec_value", rec_value, sb[0].value);
          check("rec_cycle", rec_cycle, sb[0].cyc);
          if (rec_ready) begin
            got.push_back('{int'(rec_src), int'(rec_value), rec_cycle});
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic set_src(input int i, input int v);
    taint_sum[i*SW +: SW] = SW'(v);
  endtask

  task automatic wait_cnt(input logic [31:0] k);
    for (int n = 0; n < 300; n++) begin
      if (m_run && m_cnt == k) return;
      step(1);
    end
    checks++; failures++;
    $display("FAIL wait_cnt actual=timeout required=counter %0d", k);
  endtask

  task automatic rearm();
    enable = 0; taint_sum = '0;
    step(2);
    enable = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rec_valid"}, rec_valid, 0);
    check({tag, "_rec_src"}, rec_src, 0);
    check({tag, "_rec_value"}, rec_value, 0);
    check({tag, "_rec_cycle"}, rec_cycle, 0);
    check({tag, "_coalesce"}, coalesce_count, 0);
    check({tag, "_first_taint"}, first_taint, 0);
    check({tag, "_ft_cycle"}, first_taint_cycle, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1);
  end

  initial begin
    reset = 1; enable = 0; rec_ready = 1; taint_sum = '0;
    step(2);
    check_reset_outputs("por");
    reset = 0;

    // Single change on src2 at counter 5
    got.delete();
    enable = 1;
    wait_cnt(5);
    set_src(2, 3);
    step(6);
    check("s1_count", got.size(), 1);
    if (got.size() >= 1) begin
      check("s1_src", got[0].src, 2);
      check("s1_value", got[0].value, 3);
      check("s1_cycle", got[0].cyc, 6);
    end

    // Two simultaneous changes
    rearm();
    got.delete();
    wait_cnt(5);
    set_src(1, 1); set_src(3, 2);
    step(6);
    check("s2_count", got.size(), 2);
    if (got.size() >= 2) begin
      check("s2_r0_src", got[0].src, 1);
      check("s2_r0_value", got[0].value, 1);
      check("s2_r0_cycle", got[0].cyc, 6);
      check("s2_r1_src", got[1].src, 3);
      check("s2_r1_value", got[1].value, 2);
      check("s2_r1_cycle", got[1].cyc, 7);
    end

    // Backpressure: five changes, four FIFO slots
    rearm();
    rec_ready = 0;
    got.delete();
    wait_cnt(5);
    for (int i = 0; i < 5; i++) set_src(i, 1);
    step(10);
    check("s3_valid_stalled", rec_valid, 1);
    check("s3_coalesce", coalesce_count, 0);
    rec_ready = 1;
    step(10);
    check("s3_count", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("s3_src_order", got[i].src, i);

    // Coalescing while the FIFO is full
    rearm();
    rec_ready = 0;
    got.delete();
    wait_cnt(2);
    for (int i = 4; i < 8; i++) set_src(i, 1);
    wait_cnt(10);
    set_src(0, 1);
    wait_cnt(12);
    set_src(0, 2);
    step(3);
    rec_ready = 1;
    step(10);
    check("s4_coalesce", coalesce_count, 1);
    check("s4_count", got.size(), 5);
    if (got.size() >= 5) begin
      check("s4_src0", got[4].src, 0);
      check("s4_value2", got[4].value, 2);
    end

    // First taint after a fresh reset
    reset = 1; taint_sum = '0;
    #1;
    check_reset_outputs("rst2");
    step(1);
    reset = 0;
    wait_cnt(9);
    set_src(3, 1);
    wait_cnt(12);
    set_src(1, 5);
    step(4);
    check("s5_first_taint", first_taint, 1);
    check("s5_ft_cycle", first_taint_cycle, 9);

    // Reset with records still queued
    rec_ready = 0;
    wait_cnt(20);
    set_src(0, 2); set_src(2, 3); set_src(5, 7);
    step(6);
    check("s6_queued", rec_valid, 1);
    reset = 1;
    #1;
    check_reset_outputs("s6");
    step(1);
    reset = 0; rec_ready = 1;
    got.delete();
    step(15);
    check("s6_no_stale", got.size(), 0);

    // Randomized traffic with occasional enable drops
    for (int c = 0; c < 500; c++) begin
      rec_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) set_src($urandom_range(0, NS - 1), $urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      step(1);
    end
    rec_ready = 1; enable = 0;
    step(20);
    check("drain_empty", sb.size(), 0);
    check("drain_valid", rec_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
